regfile_mp: RTL and testbench

Parametrised multi-write-port register file for the CPU datapath, the successor to the single-write 32x32 file. It adds:
- a second write port with fixed priority;
- optional same-cycle write-to-read bypass;
- an optionally hardwired zero register;
- asynchronous clearing of all registers;
- a per-register busy scoreboard that tracks in-flight writebacks for hazard detection.

---
 rtl/regfile_pkg.sv | 10 +
 rtl/regfile_if.sv | 43 ++++
 rtl/regfile_rdport.sv | 56 +++++
 rtl/regfile_mp.sv | 109 ++++++++++
 tb/tb_regfile_mp.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults for the multi-write-port register file.
// Latency: n/a (constants only).
// Backpressure: n/a.
package regfile_pkg;

  // Default data width and register count.
  localparam int XW_DEF = 32;
  localparam int NR_DEF = 32;

endpackage

// File: rtl/regfile_if.sv
// Write, read and issue signals of the register file bundled as one port.
// Latency: n/a (wires only).
// Backpressure: none; no handshake, every input is sampled on every edge.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int XW = XW_DEF,
  parameter int NR = NR_DEF
);
  localparam int AW = $clog2(NR);

  // Write port 0 (low priority)
  logic          WR0;
  logic [AW-1:0] RW0;
  logic [XW-1:0] DW0;
  // Write port 1 (high priority)
  logic          WR1;
  logic [AW-1:0] RW1;
  logic [XW-1:0] DW1;
  // Read ports
  logic [AW-1:0] RA;
  logic [AW-1:0] RB;
  logic [XW-1:0] DA;
  logic [XW-1:0] DB;
  // Scoreboard
  logic          ISSUE;
  logic [AW-1:0] RI;
  logic          BUSY_A;
  logic          BUSY_B;

  // Datapath side driving the file
  modport master (
    output WR0, RW0, DW0, WR1, RW1, DW1, RA, RB, ISSUE, RI,
    input  DA, DB, BUSY_A, BUSY_B
  );

  // The register file itself
  modport slave (
    input  WR0, RW0, DW0, WR1, RW1, DW1, RA, RB, ISSUE, RI,
    output DA, DB, BUSY_A, BUSY_B
  );

endinterface

// File: rtl/regfile_rdport.sv
// One read port: decode, bypass mux, zero-register masking and busy lookup.
// Latency: purely combinational.
// Backpressure: none.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int XW      = XW_DEF,
  parameter int NR      = NR_DEF,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1,
  localparam int AW     = $clog2(NR)
) (
  input  logic [AW-1:0] addr_i,
  input  logic [XW-1:0] rf_i [NR],
  input  logic [NR-1:0] busy_i,
  input  logic          we0_i,
  input  logic [AW-1:0] wa0_i,
  input  logic [XW-1:0] wd0_i,
  input  logic          we1_i,
  input  logic [AW-1:0] wa1_i,
  input  logic [XW-1:0] wd1_i,
  output logic [XW-1:0] dat_o,
  output logic          busy_o
);

  logic hit0;
  logic hit1;

  // A write port targets this read address in the current cycle.
  // The enables arrive already qualified (reset, discarded r0 writes).
  assign hit0 = we0_i && (wa0_i == addr_i);
  assign hit1 = we1_i && (wa1_i == addr_i);

  // Stored value by default; write-first bypass with port 1 winning;
  // the hardwired zero register overrides everything including bypass.
  always_comb begin
    dat_o  = rf_i[addr_i];
    busy_o = busy_i[addr_i];
    if (BYPASS) begin
      if (hit1) begin
        dat_o = wd1_i;
      end else if (hit0) begin
        dat_o = wd0_i;
      end
      // A consumer may proceed on bypassed data, so hide the busy bit.
      if (hit0 || hit1) begin
        busy_o = 1'b0;
      end
    end
    if (ZERO_R0 && (addr_i == '0)) begin
      dat_o  = '0;
      busy_o = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Two-write, two-read register file with optional bypass, zero r0 and a busy scoreboard.
// Latency: writes land on the rising edge; reads are combinational (same cycle with bypass).
// Backpressure: none; writes and issues are always accepted.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XW      = XW_DEF,
  parameter int NR      = NR_DEF,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1,
  localparam int AW     = $clog2(NR)
) (
  input logic       HCLK,
  input logic       HRESETn,
  regfile_if.slave  bus
);

  logic [XW-1:0] rf_q [NR];
  logic [XW-1:0] rf_d [NR];
  logic [NR-1:0] busy_q;
  logic [NR-1:0] busy_d;

  logic wr0_ok;
  logic wr1_ok;
  logic iss_ok;

  // Qualified enables. Reset suppresses everything, including the bypass
  // paths, so the outputs read as zero for as long as HRESETn is low.
  // With a hardwired r0, anything aimed at address 0 is dropped here.
  assign wr0_ok = bus.WR0 && HRESETn && !(ZERO_R0 && (bus.RW0 == '0));
  assign wr1_ok = bus.WR1 && HRESETn && !(ZERO_R0 && (bus.RW1 == '0));
  assign iss_ok = bus.ISSUE && HRESETn && !(ZERO_R0 && (bus.RI == '0));

  // Next register contents: port 1 is applied last so it wins on a collision.
  always_comb begin
    rf_d = rf_q;
    if (wr0_ok) begin
      rf_d[bus.RW0] = bus.DW0;
    end
    if (wr1_ok) begin
      rf_d[bus.RW1] = bus.DW1;
    end
  end

  // Next busy bits: writebacks clear, an issue sets last so a new producer
  // issued in the same cycle as the old one retires keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (wr0_ok) begin
      busy_d[bus.RW0] = 1'b0;
    end
    if (wr1_ok) begin
      busy_d[bus.RW1] = 1'b0;
    end
    if (iss_ok) begin
      busy_d[bus.RI] = 1'b1;
    end
  end

  // Storage and scoreboard, cleared asynchronously.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rf_q   <= '{default: '0};
      busy_q <= '0;
    end else begin
      rf_q   <= rf_d;
      busy_q <= busy_d;
    end
  end

  regfile_rdport #(
    .XW      (XW),
    .NR      (NR),
    .ZERO_R0 (ZERO_R0),
    .BYPASS  (BYPASS)
  ) u_rd_a (
    .addr_i (bus.RA),
    .rf_i   (rf_q),
    .busy_i (busy_q),
    .we0_i  (wr0_ok),
    .wa0_i  (bus.RW0),
    .wd0_i  (bus.DW0),
    .we1_i  (wr1_ok),
    .wa1_i  (bus.RW1),
    .wd1_i  (bus.DW1),
    .dat_o  (bus.DA),
    .busy_o (bus.BUSY_A)
  );

  regfile_rdport #(
    .XW      (XW),
    .NR      (NR),
    .ZERO_R0 (ZERO_R0),
    .BYPASS  (BYPASS)
  ) u_rd_b (
    .addr_i (bus.RB),
    .rf_i   (rf_q),
    .busy_i (busy_q),
    .we0_i  (wr0_ok),
    .wa0_i  (bus.RW0),
    .wd0_i  (bus.DW0),
    .we1_i  (wr1_ok),
    .wa1_i  (bus.RW1),
    .wd1_i  (bus.DW1),
    .dat_o  (bus.DB),
    .busy_o (bus.BUSY_B)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: four parameter sets driven by one shared stimulus.
// Latency: checks combinational outputs mid-cycle, model advances on each rising edge.
// Backpressure: n/a.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #10 clk = ~clk;

  // Shared stimulus, truncated per instance.
  logic        wr0, wr1, iss;
  logic [4:0]  rw0, rw1, ra, rb, ri;
  logic [63:0] dw0, dw1;

  int total = 0;
  int bad   = 0;

  // u0: 32x32 zero-r0 + bypass; u1: 32x32 neither;
  // u2: 64x16 bypass only; u3: 64x16 zero-r0 only.
  regfile_if #(.XW(32), .NR(32)) if0 ();
  regfile_if #(.XW(32), .NR(32)) if1 ();
  regfile_if #(.XW(64), .NR(16)) if2 ();
  regfile_if #(.XW(64), .NR(16)) if3 ();

  assign if0.WR0 = wr0; assign if0.RW0 = rw0; assign if0.DW0 = dw0[31:0];
  assign if0.WR1 = wr1; assign if0.RW1 = rw1; assign if0.DW1 = dw1[31:0];
  assign if0.RA = ra; assign if0.RB = rb; assign if0.ISSUE = iss; assign if0.RI = ri;

  assign if1.WR0 = wr0; assign if1.RW0 = rw0; assign if1.DW0 = dw0[31:0];
  assign if1.WR1 = wr1; assign if1.RW1 = rw1; assign if1.DW1 = dw1[31:0];
  assign if1.RA = ra; assign if1.RB = rb; assign if1.ISSUE = iss; assign if1.RI = ri;

  assign if2.WR0 = wr0; assign if2.RW0 = rw0[3:0]; assign if2.DW0 = dw0;
  assign if2.WR1 = wr1; assign if2.RW1 = rw1[3:0]; assign if2.DW1 = dw1;
  assign if2.RA = ra[3:0]; assign if2.RB = rb[3:0]; assign if2.ISSUE = iss; assign if2.RI = ri[3:0];

  assign if3.WR0 = wr0; assign if3.RW0 = rw0[3:0]; assign if3.DW0 = dw0;
  assign if3.WR1 = wr1; assign if3.RW1 = rw1[3:0]; assign if3.DW1 = dw1;
  assign if3.RA = ra[3:0]; assign if3.RB = rb[3:0]; assign if3.ISSUE = iss; assign if3.RI = ri[3:0];

  regfile_mp #(.XW(32), .NR(32), .ZERO_R0(1'b1), .BYPASS(1'b1)) u0 (.HCLK(clk), .HRESETn(rst_n), .bus(if0));
  regfile_mp #(.XW(32), .NR(32), .ZERO_R0(1'b0), .BYPASS(1'b0)) u1 (.HCLK(clk), .HRESETn(rst_n), .bus(if1));
  regfile_mp #(.XW(64), .NR(16), .ZERO_R0(1'b0), .BYPASS(1'b1)) u2 (.HCLK(clk), .HRESETn(rst_n), .bus(if2));
  regfile_mp #(.XW(64), .NR(16), .ZERO_R0(1'b1), .BYPASS(1'b0)) u3 (.HCLK(clk), .HRESETn(rst_n), .bus(if3));

  // Reference model: plain arrays of register values and busy flags.
  int          nr [4] = '{32, 32, 16, 16};
  bit          zr [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  bit          bp [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [63:0] m_rf [4][32];
  bit          m_bz [4][32];

  function automatic logic [63:0] dmask(input int d);
    return (d < 2) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  function automatic void model_clear();
    for (int d = 0; d < 4; d++)
      for (int r = 0; r < 32; r++) begin
        m_rf[d][r] = '0;
        m_bz[d][r] = 1'b0;
      end
  endfunction

  // What a read of address a must return right now.
  function automatic void model_read(input int d, input logic [4:0] a,
                                     output logic [63:0] dat, output logic bz);
    int n  = nr[d];
    int aa = int'(a) % n;
    bit h0 = wr0 && ((int'(rw0) % n) == aa);
    bit h1 = wr1 && ((int'(rw1) % n) == aa);
    if (!rst_n || (zr[d] && aa == 0)) begin
      dat = '0;
      bz  = 1'b0;
    end else if (bp[d] && h1) begin
      dat = dw1 & dmask(d);
      bz  = 1'b0;
    end else if (bp[d] && h0) begin
      dat = dw0 & dmask(d);
      bz  = 1'b0;
    end else begin
      dat = m_rf[d][aa];
      bz  = m_bz[d][aa];
    end
  endfunction

  // Effect of one rising edge out of reset.
  function automatic void model_edge();
    for (int d = 0; d < 4; d++) begin
      int n = nr[d];
      if (wr0) begin m_rf[d][int'(rw0) % n] = dw0 & dmask(d); m_bz[d][int'(rw0) % n] = 1'b0; end
      if (wr1) begin m_rf[d][int'(rw1) % n] = dw1 & dmask(d); m_bz[d][int'(rw1) % n] = 1'b0; end
      if (iss) m_bz[d][int'(ri) % n] = 1'b1;
      if (zr[d]) begin m_rf[d][0] = '0; m_bz[d][0] = 1'b0; end
    end
  endfunction

  task automatic get_obs(input int d, output logic [63:0] da, output logic [63:0] db,
                         output logic ba, output logic bb);
    case (d)
      0: begin da = {32'b0, if0.DA}; db = {32'b0, if0.DB}; ba = if0.BUSY_A; bb = if0.BUSY_B; end
      1: begin da = {32'b0, if1.DA}; db = {32'b0, if1.DB}; ba = if1.BUSY_A; bb = if1.BUSY_B; end
      2: begin da = if2.DA; db = if2.DB; ba = if2.BUSY_A; bb = if2.BUSY_B; end
      default: begin da = if3.DA; db = if3.DB; ba = if3.BUSY_A; bb = if3.BUSY_B; end
    endcase
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle from a falling edge: check all outputs, take the edge, return at the next fall.
  task automatic cyc();
    logic [63:0] oda, odb, eda, edb;
    logic        oba, obb, eba, ebb;
    #1;
    for (int d = 0; d < 4; d++) begin
      get_obs(d, oda, odb, oba, obb);
      model_read(d, ra, eda, eba);
      model_read(d, rb, edb, ebb);
      chk($sformatf("u%0d_DA", d), oda, eda);
      chk($sformatf("u%0d_DB", d), odb, edb);
      chk($sformatf("u%0d_BUSY_A", d), {63'b0, oba}, {63'b0, eba});
      chk($sformatf("u%0d_BUSY_B", d), {63'b0, obb}, {63'b0, ebb});
    end
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    wr0 = 0; wr1 = 0; iss = 0;
    rw0 = 0; rw1 = 0; ri = 0; ra = 0; rb = 0;
    dw0 = '0; dw1 = '0;
  endtask

  initial begin
    idle();
    model_clear();
    @(negedge clk);

    // Reset state
    ra = 5; rb = 9;
    cyc();
    chk("rst_u0_DA", {32'b0, if0.DA}, 64'h0);
    chk("rst_u1_BUSY_B", {63'b0, if1.BUSY_B}, 64'h0);
    rst_n = 1'b1;

    // Preload r5 on the first edge after release, then mark it busy
    wr0 = 1; rw0 = 5; dw0 = 64'h1234;
    cyc();
    idle(); iss = 1; ri = 5;
    cyc();
    idle(); ra = 5;
    #1;
    chk("pre_u0_DA", {32'b0, if0.DA}, 64'h1234);
    chk("pre_u0_BUSY_A", {63'b0, if0.BUSY_A}, 64'h1);
    // Mid-cycle reset with a write in flight clears without a clock edge
    wr1 = 1; rw1 = 5; dw1 = 64'hFFFF;
    #1 rst_n = 1'b0;
    model_clear();
    #1;
    chk("arst_u0_DA", {32'b0, if0.DA}, 64'h0);
    chk("arst_u0_BUSY_A", {63'b0, if0.BUSY_A}, 64'h0);
    chk("arst_u1_DA", {32'b0, if1.DA}, 64'h0);
    chk("arst_u1_BUSY_A", {63'b0, if1.BUSY_A}, 64'h0);
    cyc();
    chk("arst_edge_u1_DA", {32'b0, if1.DA}, 64'h0);
    rst_n = 1'b1;
    idle();

    // Collision on r7: port 1 wins
    wr0 = 1; wr1 = 1; rw0 = 7; rw1 = 7; dw0 = 64'hAAAA_AAAA; dw1 = 64'h5555_5555; ra = 7;
    cyc();
    idle(); ra = 7;
    #1;
    chk("col_u0_DA", {32'b0, if0.DA}, 64'h5555_5555);
    chk("col_u1_DA", {32'b0, if1.DA}, 64'h5555_5555);
    cyc();

    // Bypass vs read-old on r3
    wr0 = 1; rw0 = 3; dw0 = 64'h1111_1111;
    cyc();
    idle(); wr0 = 1; rw0 = 3; dw0 = 64'hDEAD_BEEF; ra = 3;
    #1;
    chk("byp_u0_DA", {32'b0, if0.DA}, 64'hDEAD_BEEF);
    chk("old_u1_DA", {32'b0, if1.DA}, 64'h1111_1111);
    cyc();
    idle(); ra = 3;
    #1;
    chk("new_u1_DA", {32'b0, if1.DA}, 64'hDEAD_BEEF);
    cyc();

    // Zero register
    wr0 = 1; wr1 = 1; rw0 = 0; rw1 = 0; dw0 = 64'hFFFF_FFFF; dw1 = 64'hFFFF_FFFF;
    iss = 1; ri = 0; ra = 0;
    cyc();
    idle(); ra = 0;
    #1;
    chk("r0_u0_DA", {32'b0, if0.DA}, 64'h0);
    chk("r0_u0_BUSY_A", {63'b0, if0.BUSY_A}, 64'h0);
    chk("r0_u1_DA", {32'b0, if1.DA}, 64'hFFFF_FFFF);
    chk("r0_u1_BUSY_A", {63'b0, if1.BUSY_A}, 64'h1);
    cyc();

    // Scoreboard on r9
    iss = 1; ri = 9; rb = 9;
    cyc();
    idle(); rb = 9;
    #1;
    chk("sb_set_u0", {63'b0, if0.BUSY_B}, 64'h1);
    chk("sb_set_u1", {63'b0, if1.BUSY_B}, 64'h1);
    wr1 = 1; rw1 = 9; dw1 = 64'h99; iss = 1; ri = 9;
    #1;
    chk("sb_wi_u0", {63'b0, if0.BUSY_B}, 64'h0);
    chk("sb_wi_u1", {63'b0, if1.BUSY_B}, 64'h1);
    cyc();
    idle(); rb = 9;
    #1;
    chk("sb_keep_u0", {63'b0, if0.BUSY_B}, 64'h1);
    chk("sb_keep_u1", {63'b0, if1.BUSY_B}, 64'h1);
    wr0 = 1; rw0 = 9; dw0 = 64'h77;
    #1;
    chk("sb_clr_same_u0", {63'b0, if0.BUSY_B}, 64'h0);
    chk("sb_clr_same_u1", {63'b0, if1.BUSY_B}, 64'h1);
    cyc();
    idle(); rb = 9;
    #1;
    chk("sb_clr_u0", {63'b0, if0.BUSY_B}, 64'h0);
    chk("sb_clr_u1", {63'b0, if1.BUSY_B}, 64'h0);
    cyc();

    // Randomized traffic, with an occasional reset under live stimulus
    for (int i = 0; i < 10000; i++) begin
      wr0 = 1'($urandom_range(0, 1));
      wr1 = 1'($urandom_range(0, 1));
      iss = 1'($urandom_range(0, 1));
      rw0 = 5'($urandom_range(0, 31));
      rw1 = ($urandom_range(0, 5) == 0) ? rw0 : 5'($urandom_range(0, 31));
      ri  = ($urandom_range(0, 3) == 0) ? rw0 : 5'($urandom_range(0, 31));
      ra  = ($urandom_range(0, 2) == 0) ? rw0 : 5'($urandom_range(0, 31));
      rb  = ($urandom_range(0, 2) == 0) ? rw1 : ($urandom_range(0, 1) == 0 ? ri : 5'($urandom_range(0, 31)));
      dw0 = {$urandom, $urandom};
      dw1 = {$urandom, $urandom};
      if (i % 2500 == 1777) begin
        rst_n = 1'b0;
        model_clear();
        cyc();
        rst_n = 1'b1;
      end else begin
        cyc();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
